// File: rtl/fb_pattern_writer.sv
// fb_pattern_writer: paints an H_VISIBLE x V_VISIBLE framebuffer region with one
// of four test patterns, one pixel per AXI write (single transaction in flight).
// Optional build macro FB_PATTERN_WRITER_BRESP_EN: when defined, a non-OKAY
// bresp sets a sticky error flag; otherwise bresp is ignored and error is 0.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | waiting for start; pattern settings latched on start
// S_WRITE | awvalid/wvalid offered for the current pixel
// S_RESP  | both channels accepted, bready high, waiting for bvalid
// S_DONE  | one-cycle done pulse after the final response
module fb_pattern_writer #(
  parameter int AXI_ADDR_WIDTH = 20,
  parameter int AXI_DATA_WIDTH = 16,
  parameter int COLOR_BITS     = 4,
  parameter int H_VISIBLE      = 640,
  parameter int V_VISIBLE      = 480,
  parameter int BASE_ADDR      = 0,
  parameter int CHECK_SHIFT    = 5
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [1:0]                  mode,
  input  logic [3*COLOR_BITS-1:0]     solid_color,
  output logic                        busy,
  output logic                        done,
  output logic                        error,
  output logic [AXI_ADDR_WIDTH-1:0]   axi_awaddr,
  output logic                        axi_awvalid,
  input  logic                        axi_awready,
  output logic [AXI_DATA_WIDTH-1:0]   axi_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0] axi_wstrb,
  output logic                        axi_wvalid,
  input  logic                        axi_wready,
  input  logic [1:0]                  axi_bresp,
  input  logic                        axi_bvalid,
  output logic                        axi_bready
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int PIX_W   = 3 * COLOR_BITS;
  // Counters must be wide enough for the frame extent and for the bits the
  // gradient and checkerboard patterns select from them.
  localparam int CNT_W   = max2(max2($clog2(H_VISIBLE + 1), $clog2(V_VISIBLE + 1)),
                                max2(CHECK_SHIFT + 1, COLOR_BITS));
  // Narrow frames (H_VISIBLE < 8) still get 1-pixel bars instead of 0-wide ones.
  localparam int BAR_W   = max2(H_VISIBLE / 8, 1);
  localparam int BAR_CW  = max2($clog2(BAR_W), 1);

  localparam logic [CNT_W-1:0]          X_LAST   = CNT_W'(H_VISIBLE - 1);
  localparam logic [CNT_W-1:0]          Y_LAST   = CNT_W'(V_VISIBLE - 1);
  localparam logic [BAR_CW-1:0]         BAR_LAST = BAR_CW'(BAR_W - 1);
  localparam logic [AXI_ADDR_WIDTH-1:0] BASE     = AXI_ADDR_WIDTH'(BASE_ADDR);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_RESP, S_DONE} state_t;

  state_t                    state, next_state;
  logic [CNT_W-1:0]          x, y;
  logic [AXI_ADDR_WIDTH-1:0] addr;
  logic [1:0]                mode_q;
  logic [PIX_W-1:0]          color_q;
  logic                      aw_done, w_done;
  logic [BAR_CW-1:0]         bar_cnt;
  logic [2:0]                bar_idx;
  logic                      aw_hs, w_hs, b_hs, last_pix;
  logic [COLOR_BITS-1:0]     r, g, b;
  logic [CNT_W-1:0]          xy;

  assign aw_hs    = axi_awvalid && axi_awready;
  assign w_hs     = axi_wvalid && axi_wready;
  assign b_hs     = (state == S_RESP) && axi_bvalid;
  assign last_pix = (x == X_LAST) && (y == Y_LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  // Next-state decode.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (start) next_state = S_WRITE;
      S_WRITE: if ((aw_done || aw_hs) && (w_done || w_hs)) next_state = S_RESP;
      S_RESP:  if (axi_bvalid) next_state = last_pix ? S_DONE : S_WRITE;
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // FSM outputs; each valid drops once its own channel has been accepted.
  always_comb begin
    busy        = (state == S_WRITE) || (state == S_RESP);
    done        = (state == S_DONE);
    axi_awvalid = (state == S_WRITE) && !aw_done;
    axi_wvalid  = (state == S_WRITE) && !w_done;
    axi_bready  = (state == S_RESP);
  end

  // Pixel position, address and bar tracking; the address simply increments
  // because row-major order makes y*H_VISIBLE+x contiguous.
  always_ff @(posedge clk) begin
    if (reset) begin
      x       <= '0;
      y       <= '0;
      addr    <= '0;
      mode_q  <= '0;
      color_q <= '0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      bar_cnt <= '0;
      bar_idx <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            mode_q  <= mode;
            color_q <= solid_color;
            x       <= '0;
            y       <= '0;
            addr    <= BASE;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            bar_cnt <= '0;
            bar_idx <= '0;
          end
        end
        S_WRITE: begin
          if (aw_hs) aw_done <= 1'b1;
          if (w_hs)  w_done  <= 1'b1;
        end
        S_RESP: begin
          if (b_hs) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            if (!last_pix) begin
              addr <= addr + 1'b1;
              if (x == X_LAST) begin
                x       <= '0;
                y       <= y + 1'b1;
                bar_cnt <= '0;
                bar_idx <= '0;
              end else begin
                x <= x + 1'b1;
                if (bar_cnt == BAR_LAST) begin
                  bar_cnt <= '0;
                  if (bar_idx != 3'd7) bar_idx <= bar_idx + 3'd1;
                end else begin
                  bar_cnt <= bar_cnt + 1'b1;
                end
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef FB_PATTERN_WRITER_BRESP_EN
  // Sticky error: cleared only by reset or an accepted start.
  always_ff @(posedge clk) begin
    if (reset)                           error <= 1'b0;
    else if (state == S_IDLE && start)   error <= 1'b0;
    else if (b_hs && axi_bresp != 2'b00) error <= 1'b1;
  end
`else
  logic unused_bresp;
  assign unused_bresp = ^axi_bresp;
  assign error        = 1'b0;
`endif

  // Pattern colour for the current pixel.
  always_comb begin
    r  = '0;
    g  = '0;
    b  = '0;
    xy = x ^ y;
    case (mode_q)
      2'd0: begin
        r = x[COLOR_BITS-1:0];
        g = y[COLOR_BITS-1:0];
        b = xy[COLOR_BITS-1:0];
      end
      2'd1: {r, g, b} = color_q;
      2'd2: begin
        r = {COLOR_BITS{x[CHECK_SHIFT] ^ y[CHECK_SHIFT]}};
        g = r;
        b = r;
      end
      default: begin
        r = {COLOR_BITS{bar_idx[2]}};
        g = {COLOR_BITS{bar_idx[1]}};
        b = {COLOR_BITS{bar_idx[0]}};
      end
    endcase
  end

  // Pixel word: zero-padded {r,g,b}, blue in the LSBs.
  always_comb begin
    axi_wdata            = '0;
    axi_wdata[PIX_W-1:0] = {r, g, b};
  end

  assign axi_awaddr = addr;
  assign axi_wstrb  = '1;

endmodule

// File: tb/tb_fb_pattern_writer.sv
// Directed bench for fb_pattern_writer: three instances (4x2, 64x64, 16x1)
// each with a small AXI write slave that logs accepted words.
module tb_fb_pattern_writer;

`ifdef FB_PATTERN_WRITER_BRESP_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  mode;
  logic [11:0] solid;
  logic        start   [3];
  logic        busy    [3];
  logic        done    [3];
  logic        error   [3];
  logic [19:0] awaddr  [3];
  logic        awvalid [3];
  logic        awready [3];
  logic [15:0] wdata   [3];
  logic [1:0]  wstrb   [3];
  logic        wvalid  [3];
  logic        wready  [3];
  logic [1:0]  bresp   [3];
  logic        bvalid  [3];
  logic        bready  [3];

  int total = 0;
  int bad   = 0;

  int aw_delay, w_delay, err_at;
  logic log_clr;

  int          aw_wait [3];
  int          w_wait  [3];
  logic        got_aw  [3];
  logic        got_w   [3];
  logic [19:0] cap_addr[3];
  logic [15:0] cap_data[3];
  int          wcount  [3];
  int          viol    [3];
  int          done_cnt[3];
  logic        w_first [3];
  logic        aw_pend [3];
  logic        w_pend  [3];
  logic [19:0] prev_addr[3];
  logic [15:0] prev_data[3];
  logic [19:0] log_addr[3][0:4095];
  logic [15:0] log_data[3][0:4095];

  always #5 clk = ~clk;

  fb_pattern_writer #(.H_VISIBLE(4), .V_VISIBLE(2)) u_a (
    .clk(clk), .reset(rst), .start(start[0]), .mode(mode), .solid_color(solid),
    .busy(busy[0]), .done(done[0]), .error(error[0]),
    .axi_awaddr(awaddr[0]), .axi_awvalid(awvalid[0]), .axi_awready(awready[0]),
    .axi_wdata(wdata[0]), .axi_wstrb(wstrb[0]), .axi_wvalid(wvalid[0]), .axi_wready(wready[0]),
    .axi_bresp(bresp[0]), .axi_bvalid(bvalid[0]), .axi_bready(bready[0]));

  fb_pattern_writer #(.H_VISIBLE(64), .V_VISIBLE(64), .CHECK_SHIFT(5)) u_b (
    .clk(clk), .reset(rst), .start(start[1]), .mode(mode), .solid_color(solid),
    .busy(busy[1]), .done(done[1]), .error(error[1]),
    .axi_awaddr(awaddr[1]), .axi_awvalid(awvalid[1]), .axi_awready(awready[1]),
    .axi_wdata(wdata[1]), .axi_wstrb(wstrb[1]), .axi_wvalid(wvalid[1]), .axi_wready(wready[1]),
    .axi_bresp(bresp[1]), .axi_bvalid(bvalid[1]), .axi_bready(bready[1]));

  fb_pattern_writer #(.H_VISIBLE(16), .V_VISIBLE(1)) u_c (
    .clk(clk), .reset(rst), .start(start[2]), .mode(mode), .solid_color(solid),
    .busy(busy[2]), .done(done[2]), .error(error[2]),
    .axi_awaddr(awaddr[2]), .axi_awvalid(awvalid[2]), .axi_awready(awready[2]),
    .axi_wdata(wdata[2]), .axi_wstrb(wstrb[2]), .axi_wvalid(wvalid[2]), .axi_wready(wready[2]),
    .axi_bresp(bresp[2]), .axi_bvalid(bvalid[2]), .axi_bready(bready[2]));

  // Slave readiness: each channel accepts after its configured wait.
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      awready[k] = awvalid[k] && (aw_wait[k] >= aw_delay);
      wready[k]  = wvalid[k] && (w_wait[k] >= w_delay);
    end
  end

  // Slave model: capture, log, respond, and flag protocol violations.
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rst || log_clr) begin
        aw_wait[k] <= 0; w_wait[k] <= 0; got_aw[k] <= 1'b0; got_w[k] <= 1'b0;
        bvalid[k] <= 1'b0; bresp[k] <= 2'b00; wcount[k] <= 0; viol[k] <= 0;
        done_cnt[k] <= 0; w_first[k] <= 1'b0; aw_pend[k] <= 1'b0; w_pend[k] <= 1'b0;
        prev_addr[k] <= '0; prev_data[k] <= '0; cap_addr[k] <= '0; cap_data[k] <= '0;
      end else begin
        aw_wait[k] <= (awvalid[k] && !awready[k]) ? aw_wait[k] + 1 : 0;
        w_wait[k]  <= (wvalid[k] && !wready[k]) ? w_wait[k] + 1 : 0;
        if (awvalid[k] && awready[k]) begin got_aw[k] <= 1'b1; cap_addr[k] <= awaddr[k]; end
        if (wvalid[k] && wready[k])   begin got_w[k]  <= 1'b1; cap_data[k] <= wdata[k];  end
        if (awvalid[k] && !wvalid[k]) w_first[k] <= 1'b1;
        if (done[k]) done_cnt[k] <= done_cnt[k] + 1;
        viol[k] <= viol[k]
          + ((awvalid[k] && awready[k] && got_aw[k]) ? 1 : 0)
          + ((wvalid[k] && wready[k] && got_w[k]) ? 1 : 0)
          + ((aw_pend[k] && (!awvalid[k] || awaddr[k] != prev_addr[k])) ? 1 : 0)
          + ((w_pend[k] && (!wvalid[k] || wdata[k] != prev_data[k])) ? 1 : 0)
          + ((wstrb[k] != 2'b11) ? 1 : 0);
        aw_pend[k]   <= awvalid[k] && !awready[k];
        w_pend[k]    <= wvalid[k] && !wready[k];
        prev_addr[k] <= awaddr[k];
        prev_data[k] <= wdata[k];
        if (bvalid[k] && bready[k]) begin
          bvalid[k] <= 1'b0;
        end else if (got_aw[k] && got_w[k] && !bvalid[k]) begin
          bvalid[k] <= 1'b1;
          bresp[k]  <= (wcount[k] == err_at) ? 2'b10 : 2'b00;
          got_aw[k] <= 1'b0;
          got_w[k]  <= 1'b0;
          if (wcount[k] < 4096) begin
            log_addr[k][wcount[k]] <= cap_addr[k];
            log_data[k][wcount[k]] <= cap_data[k];
          end
          wcount[k] <= wcount[k] + 1;
        end
      end
    end
  end

  task automatic clear_logs();
    log_clr = 1'b1;
    @(negedge clk);
    log_clr = 1'b0;
  endtask

  // Pulse start on instance k and wait (bounded) for done; called at a negedge.
  task automatic run_frame(input int k, input int budget, output int busy_low, output bit to);
    start[k] = 1'b1;
    @(negedge clk);
    start[k] = 1'b0;
    busy_low = 0;
    to = 1'b1;
    for (int n = 0; n < budget; n++) begin
      if (done[k]) begin
        to = 1'b0;
        break;
      end
      if (!busy[k]) busy_low++;
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    total++; if (busy[0] !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b want=0", busy[0]); end
    total++; if (done[0] !== 1'b0) begin bad++; $display("FAIL reset_done got=%0b want=0", done[0]); end
    total++; if (error[0] !== 1'b0) begin bad++; $display("FAIL reset_error got=%0b want=0", error[0]); end
    total++; if (awvalid[0] !== 1'b0 || wvalid[0] !== 1'b0 || bready[0] !== 1'b0) begin
      bad++; $display("FAIL reset_valids got=%0b%0b%0b want=000", awvalid[0], wvalid[0], bready[0]);
    end
    total++; if (awaddr[0] !== 20'h0) begin bad++; $display("FAIL reset_awaddr got=%0h want=0", awaddr[0]); end
    total++; if (wdata[0] !== 16'h0) begin bad++; $display("FAIL reset_wdata got=%0h want=0", wdata[0]); end
  endtask

  task automatic test_gradient();
    logic [15:0] exp_g [8] = '{16'h000, 16'h101, 16'h202, 16'h303,
                               16'h011, 16'h110, 16'h213, 16'h312};
    int bl; bit to;
    clear_logs();
    mode = 2'd0; aw_delay = 0; w_delay = 0;
    run_frame(0, 200, bl, to);
    total++; if (to) begin bad++; $display("FAIL grad_timeout got=timeout want=done"); end
    total++; if (wcount[0] != 8) begin bad++; $display("FAIL grad_count got=%0d want=8", wcount[0]); end
    total++; if (bl != 0) begin bad++; $display("FAIL grad_busy_gap got=%0d want=0", bl); end
    total++; if (done_cnt[0] != 1) begin bad++; $display("FAIL grad_done_pulses got=%0d want=1", done_cnt[0]); end
    total++; if (viol[0] != 0) begin bad++; $display("FAIL grad_protocol got=%0d want=0", viol[0]); end
    for (int i = 0; i < 8; i++) begin
      total++;
      if (log_addr[0][i] !== 20'(i) || log_data[0][i] !== exp_g[i]) begin
        bad++;
        $display("FAIL grad_pixel%0d got=%0h/%0h want=%0h/%0h", i, log_addr[0][i], log_data[0][i], i, exp_g[i]);
      end
    end
  endtask

  task automatic test_solid_delayed();
    int bl; bit to;
    clear_logs();
    mode = 2'd1; solid = 12'hABC; aw_delay = 3; w_delay = 0;
    fork
      run_frame(0, 300, bl, to);
      begin
        repeat (6) @(negedge clk);
        mode = 2'd2; solid = 12'h123;
      end
    join
    aw_delay = 0;
    total++; if (to) begin bad++; $display("FAIL solid_timeout got=timeout want=done"); end
    total++; if (wcount[0] != 8) begin bad++; $display("FAIL solid_count got=%0d want=8", wcount[0]); end
    total++; if (w_first[0] !== 1'b1) begin bad++; $display("FAIL solid_wvalid_first got=%0b want=1", w_first[0]); end
    total++; if (viol[0] != 0) begin bad++; $display("FAIL solid_protocol got=%0d want=0", viol[0]); end
    for (int i = 0; i < 8; i++) begin
      total++;
      if (log_addr[0][i] !== 20'(i) || log_data[0][i] !== 16'h0ABC) begin
        bad++;
        $display("FAIL solid_pixel%0d got=%0h/%0h want=%0h/0abc", i, log_addr[0][i], log_data[0][i], i);
      end
    end
  endtask

  task automatic test_checker();
    int bl; bit to;
    clear_logs();
    mode = 2'd2;
    run_frame(1, 30000, bl, to);
    total++; if (to) begin bad++; $display("FAIL chk_timeout got=timeout want=done"); end
    total++; if (wcount[1] != 4096) begin bad++; $display("FAIL chk_count got=%0d want=4096", wcount[1]); end
    total++; if (log_data[1][0] !== 16'h000) begin bad++; $display("FAIL chk_0_0 got=%0h want=000", log_data[1][0]); end
    total++; if (log_data[1][32] !== 16'hFFF) begin bad++; $display("FAIL chk_32_0 got=%0h want=fff", log_data[1][32]); end
    total++; if (log_data[1][2048] !== 16'hFFF) begin bad++; $display("FAIL chk_0_32 got=%0h want=fff", log_data[1][2048]); end
    total++; if (log_data[1][2080] !== 16'h000 || log_addr[1][2080] !== 20'd2080) begin
      bad++; $display("FAIL chk_32_32 got=%0h@%0d want=000@2080", log_data[1][2080], log_addr[1][2080]);
    end
    total++; if (log_addr[1][4095] !== 20'd4095) begin bad++; $display("FAIL chk_last_addr got=%0d want=4095", log_addr[1][4095]); end
    total++; if (viol[1] != 0) begin bad++; $display("FAIL chk_protocol got=%0d want=0", viol[1]); end
  endtask

  task automatic test_bars();
    logic [15:0] bar_c [8] = '{16'h000, 16'h00F, 16'h0F0, 16'h0FF,
                               16'hF00, 16'hF0F, 16'hFF0, 16'hFFF};
    int bl; bit to;
    clear_logs();
    mode = 2'd3;
    run_frame(2, 200, bl, to);
    total++; if (to) begin bad++; $display("FAIL bars_timeout got=timeout want=done"); end
    total++; if (wcount[2] != 16) begin bad++; $display("FAIL bars_count got=%0d want=16", wcount[2]); end
    for (int i = 0; i < 16; i++) begin
      total++;
      if (log_data[2][i] !== bar_c[i/2]) begin
        bad++; $display("FAIL bars_pixel%0d got=%0h want=%0h", i, log_data[2][i], bar_c[i/2]);
      end
    end
  endtask

  task automatic test_error();
    int bl; bit to;
    clear_logs();
    mode = 2'd0; err_at = 5;
    run_frame(0, 200, bl, to);
    err_at = -1;
    total++; if (to) begin bad++; $display("FAIL err_timeout got=timeout want=done"); end
    total++; if (error[0] !== ERR_EN) begin bad++; $display("FAIL err_sticky got=%0b want=%0b", error[0], ERR_EN); end
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    total++; if (error[0] !== 1'b0) begin bad++; $display("FAIL err_clear got=%0b want=0", error[0]); end
    to = 1'b1;
    for (int n = 0; n < 200; n++) begin
      if (done[0]) begin to = 1'b0; break; end
      @(negedge clk);
    end
    @(negedge clk);
    total++; if (to || error[0] !== 1'b0) begin bad++; $display("FAIL err_clean_frame got=%0b/to%0b want=0", error[0], to); end
  endtask

  task automatic test_back_to_back();
    bit to;
    clear_logs();
    mode = 2'd0;
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    to = 1'b1;
    for (int n = 0; n < 100; n++) begin
      if (bready[0] && awaddr[0] == 20'd3) begin to = 1'b0; break; end
      @(negedge clk);
    end
    total++; if (to) begin bad++; $display("FAIL rst_reach_pixel3 got=timeout want=resp"); end
    rst = 1'b1;
    @(negedge clk);
    total++; if (awvalid[0] !== 1'b0 || wvalid[0] !== 1'b0 || bready[0] !== 1'b0 || busy[0] !== 1'b0) begin
      bad++; $display("FAIL rst_midframe got=%0b%0b%0b%0b want=0000", awvalid[0], wvalid[0], bready[0], busy[0]);
    end
    total++; if (awaddr[0] !== 20'h0) begin bad++; $display("FAIL rst_awaddr got=%0h want=0", awaddr[0]); end
    rst = 1'b0;
    @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (6) @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    to = 1'b1;
    for (int n = 0; n < 200; n++) begin
      if (done[0]) begin to = 1'b0; break; end
      @(negedge clk);
    end
    repeat (8) @(negedge clk);
    total++; if (to) begin bad++; $display("FAIL b2b_timeout got=timeout want=done"); end
    total++; if (log_addr[0][0] !== 20'h0) begin bad++; $display("FAIL b2b_first_addr got=%0h want=0", log_addr[0][0]); end
    total++; if (wcount[0] != 8 || done_cnt[0] != 1) begin
      bad++; $display("FAIL b2b_ignored_start got=%0d writes/%0d done want=8/1", wcount[0], done_cnt[0]);
    end
    total++; if (busy[0] !== 1'b0) begin bad++; $display("FAIL b2b_idle got=%0b want=0", busy[0]); end
  endtask

  initial begin
    rst = 1'b1;
    log_clr = 1'b0;
    mode = 2'd0;
    solid = 12'h000;
    aw_delay = 0;
    w_delay = 0;
    err_at = -1;
    for (int k = 0; k < 3; k++) start[k] = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b0;
    @(negedge clk);
    test_gradient();
    test_solid_delayed();
    test_checker();
    test_bars();
    test_error();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
